// File: rtl/mpu_frame_pkg.sv
// Shared types and constants for the MPU6050 burst-read frame assembler.
package mpu_frame_pkg;

  localparam int unsigned IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  localparam logic [7:0] MPU_FIRST_REG = 8'h3B;

  localparam logic [IDX_W-1:0] IDX_AXH = 4'd0;
  localparam logic [IDX_W-1:0] IDX_AXL = 4'd1;
  localparam logic [IDX_W-1:0] IDX_AYH = 4'd2;
  localparam logic [IDX_W-1:0] IDX_AYL = 4'd3;
  localparam logic [IDX_W-1:0] IDX_AZH = 4'd4;
  localparam logic [IDX_W-1:0] IDX_AZL = 4'd5;
  localparam logic [IDX_W-1:0] IDX_TH  = 4'd6;
  localparam logic [IDX_W-1:0] IDX_TL  = 4'd7;
  localparam logic [IDX_W-1:0] IDX_GXH = 4'd8;
  localparam logic [IDX_W-1:0] IDX_GXL = 4'd9;
  localparam logic [IDX_W-1:0] IDX_GYH = 4'd10;
  localparam logic [IDX_W-1:0] IDX_GYL = 4'd11;
  localparam logic [IDX_W-1:0] IDX_GZH = 4'd12;
  localparam logic [IDX_W-1:0] IDX_GZL = 4'd13;

  typedef struct packed {
    logic [15:0] ax;
    logic [15:0] ay;
    logic [15:0] az;
    logic [15:0] gz;
  } mpu_sample_t;

  // Drop one burst byte into its word slot; temperature and gyro X/Y bytes are not kept.
  function automatic mpu_sample_t put_byte(input mpu_sample_t s,
                                           input logic [IDX_W-1:0] i,
                                           input logic [7:0] b);
    mpu_sample_t r;
    r = s;
    case (i)
      IDX_AXH: r.ax[15:8] = b;
      IDX_AXL: r.ax[7:0]  = b;
      IDX_AYH: r.ay[15:8] = b;
      IDX_AYL: r.ay[7:0]  = b;
      IDX_AZH: r.az[15:8] = b;
      IDX_AZL: r.az[7:0]  = b;
      IDX_GZH: r.gz[15:8] = b;
      IDX_GZL: r.gz[7:0]  = b;
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/accel_avg4.sv
// Four-frame moving average for one acceleration axis; output registered one cycle after in_vld.
module accel_avg4 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_vld,
  input  logic [15:0] din,
  output logic [15:0] dout
);

  logic [3:0][15:0]   hist;
  logic signed [17:0] sum;
  logic signed [17:0] sum_c;

  // Running sum: add the newest sample, drop the one falling out of the window.
  always_comb begin
    sum_c = sum + 18'($signed(din)) - 18'($signed(hist[3]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
      sum  <= '0;
      dout <= '0;
    end else if (in_vld) begin
      hist <= {hist[2:0], din};
      sum  <= sum_c;
      dout <= sum_c[17:2];
    end
  end

endmodule

// File: rtl/mpu_accel_frame.sv
// Assembles an MPU6050 burst read into frame-atomic accel/gyro words.
// Optional ACCEL_AVG4_EN: 4-frame moving average on AX/AY/AZ (data_vld latency 2).
module mpu_accel_frame
  import mpu_frame_pkg::*;
#(
  parameter int unsigned FRAME_BYTES = 14,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_vld,
  input  logic        frame_start,
  output logic [15:0] AX_DATA,
  output logic [15:0] AY_DATA,
  output logic [15:0] AZ_DATA,
  output logic [15:0] GZ_DATA,
  output logic        data_vld,
  output logic        frame_err,
  output logic [15:0] sample_cnt
);

  localparam int unsigned GAP_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);
  localparam bit   HAS_GZ   = (FRAME_BYTES == 14);

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   idx;
  logic [GAP_W-1:0]   gap_cnt;
  mpu_sample_t        shadow;
  mpu_sample_t        shadow_c;
  mpu_sample_t        raw;
  logic               raw_vld;

  logic               start_c;
  logic               accept_c;
  logic               commit_c;
  logic               timeout_c;
  logic               err_c;
  logic               cnt_inc_c;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (byte_vld && frame_start) state_nxt = COLLECT;
      end
      COLLECT: begin
        if (byte_vld && !frame_start && idx == LAST_IDX) state_nxt = COMMIT;
        else if (!byte_vld && gap_cnt >= GAP_W'(TIMEOUT_CYC)) state_nxt = IDLE;
      end
      COMMIT: begin
        state_nxt = (byte_vld && frame_start) ? COLLECT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Per-cycle control decoded from the current state
  always_comb begin
    start_c   = 1'b0;
    accept_c  = 1'b0;
    commit_c  = 1'b0;
    timeout_c = 1'b0;
    err_c     = 1'b0;
    unique case (state)
      IDLE, COMMIT: begin
        start_c  = byte_vld && frame_start;
        accept_c = start_c;
      end
      COLLECT: begin
        start_c   = byte_vld && frame_start;
        accept_c  = byte_vld;
        commit_c  = byte_vld && !frame_start && idx == LAST_IDX;
        timeout_c = !byte_vld && gap_cnt >= GAP_W'(TIMEOUT_CYC);
        err_c     = start_c || timeout_c;
      end
      default: ;
    endcase
  end

  // A restarted frame writes slot 0; otherwise the byte lands at idx.
  always_comb begin
    shadow_c = shadow;
    if (accept_c) shadow_c = put_byte(shadow, start_c ? '0 : idx, byte_in);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx       <= '0;
      gap_cnt   <= '0;
      shadow    <= '0;
      raw       <= '0;
      raw_vld   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      shadow    <= shadow_c;
      raw_vld   <= commit_c;
      frame_err <= err_c;

      if (start_c)                    idx <= IDX_W'(1);
      else if (commit_c || timeout_c) idx <= '0;
      else if (accept_c)              idx <= idx + IDX_W'(1);

      if (accept_c || state_nxt != COLLECT) gap_cnt <= '0;
      else                                  gap_cnt <= gap_cnt + GAP_W'(1);

      // Raw words include the final byte sampled on this same edge.
      if (commit_c) begin
        raw <= shadow_c;
        if (!HAS_GZ) raw.gz <= '0;
      end
    end
  end

`ifdef ACCEL_AVG4_EN
  logic [15:0] gz_d;
  logic        vld_d;

  accel_avg4 u_avg_ax (.clk(clk), .rst_n(reset), .in_vld(raw_vld), .din(raw.ax), .dout(AX_DATA));
  accel_avg4 u_avg_ay (.clk(clk), .rst_n(reset), .in_vld(raw_vld), .din(raw.ay), .dout(AY_DATA));
  accel_avg4 u_avg_az (.clk(clk), .rst_n(reset), .in_vld(raw_vld), .din(raw.az), .dout(AZ_DATA));

  // Gyro and the valid pulse ride one stage behind to stay aligned with the averages.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gz_d  <= '0;
      vld_d <= 1'b0;
    end else begin
      vld_d <= raw_vld;
      if (raw_vld) gz_d <= raw.gz;
    end
  end

  assign GZ_DATA   = gz_d;
  assign data_vld  = vld_d;
  assign cnt_inc_c = raw_vld;
`else
  assign AX_DATA   = raw.ax;
  assign AY_DATA   = raw.ay;
  assign AZ_DATA   = raw.az;
  assign GZ_DATA   = raw.gz;
  assign data_vld  = raw_vld;
  assign cnt_inc_c = commit_c;
`endif

  // Committed-frame counter, updated on the same edge as data_vld.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         sample_cnt <= '0;
    else if (cnt_inc_c) sample_cnt <= sample_cnt + 16'd1;
  end

endmodule

// File: tb/tb_mpu_accel_frame.sv
// Scoreboard bench for mpu_accel_frame (default build, raw words, latency 1).
module tb_mpu_accel_frame;

  localparam int unsigned TIMEOUT_CYC = 50000;

  typedef logic [7:0] frame_t [14];

  typedef struct {
    logic [15:0] ax;
    logic [15:0] ay;
    logic [15:0] az;
    logic [15:0] gz;
    logic [15:0] cnt;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_vld = 1'b0;
  logic        frame_start = 1'b0;
  logic [15:0] AX_DATA, AY_DATA, AZ_DATA, GZ_DATA, sample_cnt;
  logic        data_vld, frame_err;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [15:0] exp_cnt = 16'd0;

  exp_t exp_q[$];
  int   err_q[$];
  exp_t mon_e;
  int   mon_c;

  frame_t f1, f2, f3, f4, f5, f6;

  mpu_accel_frame #(.FRAME_BYTES(14), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .reset(reset), .byte_in(byte_in), .byte_vld(byte_vld),
    .frame_start(frame_start), .AX_DATA(AX_DATA), .AY_DATA(AY_DATA),
    .AZ_DATA(AZ_DATA), .GZ_DATA(GZ_DATA), .data_vld(data_vld),
    .frame_err(frame_err), .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop and compare whenever the DUT presents data_vld or frame_err.
  always @(negedge clk) begin
    if (reset) begin
      if (data_vld) begin
        if (exp_q.size() == 0) check("unexpected_data_vld", 32'd1, 32'd0);
        else begin
          mon_e = exp_q.pop_front();
          check("ax", 32'(AX_DATA), 32'(mon_e.ax));
          check("ay", 32'(AY_DATA), 32'(mon_e.ay));
          check("az", 32'(AZ_DATA), 32'(mon_e.az));
          check("gz", 32'(GZ_DATA), 32'(mon_e.gz));
          check("sample_cnt", 32'(sample_cnt), 32'(mon_e.cnt));
          check("vld_cycle", 32'(cyc), 32'(mon_e.cyc));
        end
      end
      if (frame_err) begin
        if (err_q.size() == 0) check("unexpected_frame_err", 32'd1, 32'd0);
        else begin
          mon_c = err_q.pop_front();
          check("err_cycle", 32'(cyc), 32'(mon_c));
        end
      end
    end
  end

  task automatic put(input logic [7:0] b, input logic fs);
    byte_in = b; byte_vld = 1'b1; frame_start = fs;
    @(posedge clk); #1;
    byte_vld = 1'b0; frame_start = 1'b0;
  endtask

  task automatic send_partial(input frame_t f, input int n);
    for (int i = 0; i < n; i++) put(f[i], i == 0);
  endtask

  task automatic send_frame(input frame_t f, input logic [15:0] ax, input logic [15:0] ay,
                            input logic [15:0] az, input logic [15:0] gz, input bit exp_err);
    exp_t e;
    put(f[0], 1'b1);
    if (exp_err) err_q.push_back(cyc);
    for (int i = 1; i < 14; i++) put(f[i], 1'b0);
    exp_cnt = exp_cnt + 16'd1;
    e.ax = ax; e.ay = ay; e.az = az; e.gz = gz; e.cnt = exp_cnt; e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    repeat (3) @(posedge clk);
    #1;
    check(name, 32'(exp_q.size() + err_q.size()), 32'd0);
  endtask

  task automatic check_outputs(input string tag, input logic [15:0] ax, input logic [15:0] ay,
                               input logic [15:0] az, input logic [15:0] gz, input logic [15:0] cnt);
    check({tag, "_ax"}, 32'(AX_DATA), 32'(ax));
    check({tag, "_ay"}, 32'(AY_DATA), 32'(ay));
    check({tag, "_az"}, 32'(AZ_DATA), 32'(az));
    check({tag, "_gz"}, 32'(GZ_DATA), 32'(gz));
    check({tag, "_cnt"}, 32'(sample_cnt), 32'(cnt));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    f1 = '{8'h00, 8'h10, 8'hFF, 8'hF0, 8'h40, 8'h00, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'h12, 8'h34};
    f2 = '{8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hEF, 8'hF1, 8'hF2, 8'hF3};
    f3 = '{8'h80, 8'h00, 8'h7F, 8'hFF, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'hFE, 8'hDC};
    f4 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E};
    f5 = '{8'hFF, 8'hFF, 8'hFF, 8'hFE, 8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h7F, 8'h00};
    f6 = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h44, 8'h44};

    repeat (3) @(posedge clk);
    #1;
    check_outputs("rst", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    check("rst_data_vld", 32'(data_vld), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Stray bytes without frame_start are ignored in IDLE.
    put(8'hEE, 1'b0);
    put(8'hDD, 1'b0);
    send_frame(f1, 16'h0010, 16'hFFF0, 16'h4000, 16'h1234, 1'b0);
    drain("drain_f1");

    // Truncated frame: 7 bytes then silence until the gap timeout.
    send_partial(f2, 7);
    err_q.push_back(cyc + TIMEOUT_CYC + 1);
    repeat (TIMEOUT_CYC + 5) @(posedge clk);
    #1;
    check("timeout_err_seen", 32'(err_q.size()), 32'd0);
    check_outputs("hold", 16'h0010, 16'hFFF0, 16'h4000, 16'h1234, 16'd1);

    // Restart inside a frame: 9 bytes, then a new frame_start begins a full frame.
    send_partial(f2, 9);
    send_frame(f3, 16'h8000, 16'h7FFF, 16'h0001, 16'hFEDC, 1'b1);
    drain("drain_restart");

    // Back-to-back frames, second frame_start lands in the COMMIT cycle.
    send_frame(f4, 16'h0102, 16'h0304, 16'h0506, 16'h0D0E, 1'b0);
    send_frame(f5, 16'hFFFF, 16'hFFFE, 16'h8001, 16'h7F00, 1'b0);
    drain("drain_b2b");

    // Reset in the middle of a frame: everything clears, no frame_err.
    send_partial(f2, 5);
    reset = 1'b0;
    #1;
    check_outputs("midrst", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    exp_cnt = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("postrst", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    send_frame(f6, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b0);
    drain("drain_f6");
    check_outputs("final", 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
